// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM with
// break detection, and sticky ready/overrun flags cleared by rd_ack.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [10:0] HALF_LAST = 11'(CLKS_PER_BIT / 2 - 1);
    localparam logic [10:0] BIT_LAST  = 11'(CLKS_PER_BIT - 1);

    state_t      state, state_n;
    logic [10:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic        rx_meta, rx_s;
    logic        valid_n, ferr_n, ready_n, overrun_n;

    // Synchronizer flops reset to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        idx_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 11'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 11'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 11'd1;
                end
            end
            BREAK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake: rx_valid pulses for one cycle as rx_data updates and rx_ready
    // rises with it; rx_ready stays high until a cycle with rd_ack=1 and no new
    // byte. A byte landing while rx_ready=1 and rd_ack=0 sets overrun, but
    // still overwrites rx_data. rd_ack clears overrun too.
    always_comb begin
        ready_n   = rx_ready;
        overrun_n = overrun;
        if (valid_n)     ready_n = 1'b1;
        else if (rd_ack) ready_n = 1'b0;
        if (valid_n && rx_ready && !rd_ack) overrun_n = 1'b1;
        else if (rd_ack)                    overrun_n = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
            rx_ready  <= ready_n;
            overrun   <= overrun_n;
            if (valid_n) rx_data <= shift;
        end
    end

    assign rx_busy   = (state != IDLE);
    assign state_dbg = state;

endmodule
